// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC generator: sequential PC+4 fetch, one-cycle-late BTB
// redirect with wrong-path squash, and an in-order FIFO of predicted next PCs
// that EX resolutions are checked against to detect mispredicts and flush.
module fetch_pc_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       en,
  input  logic [63:0]                predicted_branch_pc,
  input  logic                       resolve_valid,
  input  logic [63:0]                resolve_next_pc,
  output logic [63:0]                current_pc,
  output logic [63:0]                prev_pc,
  output logic                       fetch_valid,
  output logic                       squash,
  output logic                       flush,
  output logic [31:0]                mispredict_count,
  output logic [$clog2(DEPTH):0]     inflight
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t             state;
  logic               pend;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   occ;

  // Only the predicted next PC is needed to judge a resolution, so the
  // issued PC of each in-flight entry is not retained.
  logic [63:0]        pred_fifo [DEPTH];

  logic               has_head;
  logic               mispredict;
  logic               btb_hit;
  logic               push;
  logic               pop;
  logic               btb_redirect;
  logic               room;
  logic [63:0]        push_pred;
  logic [SUM_W-1:0]   occ_sum;

  // Resolve / BTB decode and issue qualification for this cycle
  always_comb begin
    has_head     = (occ != '0);
    mispredict   = en & resolve_valid & has_head &
                   (pred_fifo[rd_ptr] != resolve_next_pc);
    btb_hit      = (predicted_branch_pc != 64'h0);
    push         = en & ~mispredict & pend;
    pop          = en & resolve_valid & has_head & ~mispredict;
    btb_redirect = push & btb_hit & (predicted_branch_pc != current_pc) &
                   (state == RUN);
    push_pred    = btb_hit ? predicted_branch_pc : prev_pc + 64'd4;
    occ_sum      = SUM_W'(occ) + SUM_W'(pend);
    room         = (occ_sum < SUM_W'(DEPTH));
    fetch_valid  = en & (state == RUN) & room & ~mispredict & ~btb_redirect;
    squash       = btb_redirect;
  end

  assign inflight = occ;

  // Prediction storage; contents are only meaningful below occ
  always_ff @(posedge clk) begin
    if (push) begin
      pred_fifo[wr_ptr] <= push_pred;
    end
  end

  // FIFO pointers and occupancy; a mispredict discards every entry
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (mispredict) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // PC sequencing, RUN/FLUSH state, flush pulse and mispredict counter
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state            <= RUN;
      current_pc       <= RESET_PC;
      prev_pc          <= 64'h0;
      pend             <= 1'b0;
      flush            <= 1'b0;
      mispredict_count <= 32'h0;
    end else if (en) begin
      if (mispredict) begin
        state      <= FLUSH;
        current_pc <= resolve_next_pc;
        pend       <= 1'b0;
        flush      <= 1'b1;
        if (mispredict_count != '1) begin
          mispredict_count <= mispredict_count + 32'd1;
        end
      end else begin
        state <= RUN;
        flush <= 1'b0;
        if (btb_redirect) begin
          current_pc <= predicted_branch_pc;
          pend       <= 1'b0;
        end else if (fetch_valid) begin
          prev_pc    <= current_pc;
          current_pc <= current_pc + 64'd4;
          pend       <= 1'b1;
        end else begin
          pend <= 1'b0;
        end
      end
    end
  end

endmodule
